// File: rtl/rk_store_rev.sv
// Round-key store: captures an expander's forward schedule (0..NR) and replays it NR..0 over valid/ready.
// Optional RK_INVMIX_EN applies InvMixColumns to rounds 1..NR-1 on the read path (equivalent inverse cipher).
module rk_store_rev #(
  parameter int NR    = 12,
  parameter int CNT_W = 4
) (
  input  logic             mclk,
  input  logic             arst_n,
  input  logic [0:127]     rk_in,
  input  logic [CNT_W-1:0] rk_in_count,
  input  logic             rk_in_le,
  input  logic             rd_start,
  input  logic             rd_ready,
  output logic [0:127]     rd_key,
  output logic [CNT_W-1:0] rd_round,
  output logic             rd_valid,
  output logic             keys_ready,
  output logic             wr_err
);

  typedef enum logic [1:0] {IDLE, FILL, FULL, READ} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(NR);

  state_t           state;
  logic [CNT_W-1:0] wr_ptr;
  logic [CNT_W-1:0] rd_ptr;
  logic [127:0]     mem [0:NR];
  logic [127:0]     raw_key;
  logic [127:0]     out_key;
  logic             cnt_zero;
  logic             cnt_next;
  logic             wr_ok;

`ifdef RK_INVMIX_EN
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [7:0] m9 [4];
    logic [7:0] m11 [4];
    logic [7:0] m13 [4];
    logic [7:0] m14 [4];
    logic [31:0] r;
    for (int j = 0; j < 4; j++) begin
      a[j]   = c[31-8*j -: 8];
      x2[j]  = xt(a[j]);
      x4[j]  = xt(x2[j]);
      x8[j]  = xt(x4[j]);
      m9[j]  = x8[j] ^ a[j];
      m11[j] = x8[j] ^ x2[j] ^ a[j];
      m13[j] = x8[j] ^ x4[j] ^ a[j];
      m14[j] = x8[j] ^ x4[j] ^ x2[j];
    end
    r[31:24] = m14[0] ^ m11[1] ^ m13[2] ^ m9[3];
    r[23:16] = m9[0]  ^ m14[1] ^ m11[2] ^ m13[3];
    r[15:8]  = m13[0] ^ m9[1]  ^ m14[2] ^ m11[3];
    r[7:0]   = m11[0] ^ m13[1] ^ m9[2]  ^ m14[3];
    return r;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] k);
    logic [127:0] r;
    for (int i = 0; i < 4; i++) begin
      r[127-32*i -: 32] = inv_mix_col(k[127-32*i -: 32]);
    end
    return r;
  endfunction
`endif

  // A write is legal as a (re)start at index 0 outside READ, or as the next index during FILL.
  always_comb begin
    cnt_zero = (rk_in_count == '0);
    cnt_next = (state == FILL) && (rk_in_count == wr_ptr);
    wr_ok    = rk_in_le && ((cnt_zero && (state != READ)) || cnt_next);
  end

  always_ff @(posedge mclk) begin
    if (wr_ok) begin
      mem[rk_in_count] <= rk_in;
    end
  end

  always_ff @(posedge mclk or negedge arst_n) begin
    if (!arst_n) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      rd_valid   <= 1'b0;
      keys_ready <= 1'b0;
      wr_err     <= 1'b0;
    end else begin
      wr_err <= rk_in_le && !wr_ok;
      case (state)
        IDLE: begin
          if (rk_in_le && cnt_zero) begin
            wr_ptr <= CNT_W'(1);
            state  <= FILL;
          end
        end
        FILL: begin
          if (rk_in_le && cnt_zero) begin
            wr_ptr <= CNT_W'(1);
          end else if (cnt_next && rk_in_le) begin
            if (wr_ptr == LAST) begin
              wr_ptr     <= '0;
              keys_ready <= 1'b1;
              state      <= FULL;
            end else begin
              wr_ptr <= wr_ptr + 1'b1;
            end
          end
        end
        FULL: begin
          // A fresh schedule wins over a simultaneous replay request.
          if (rk_in_le && cnt_zero) begin
            keys_ready <= 1'b0;
            wr_ptr     <= CNT_W'(1);
            state      <= FILL;
          end else if (rd_start) begin
            rd_ptr   <= LAST;
            rd_valid <= 1'b1;
            state    <= READ;
          end
        end
        READ: begin
          if (rd_ready) begin
            if (rd_ptr == '0) begin
              rd_valid <= 1'b0;
              state    <= FULL;
            end else begin
              rd_ptr <= rd_ptr - 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    raw_key = mem[rd_ptr];
`ifdef RK_INVMIX_EN
    out_key = ((rd_ptr != '0) && (rd_ptr != LAST)) ? inv_mix(raw_key) : raw_key;
`else
    out_key = raw_key;
`endif
    rd_key   = rd_valid ? out_key : '0;
    rd_round = rd_ptr;
  end

endmodule

// File: tb/tb_rk_store_rev.sv
// Randomized scoreboard bench for rk_store_rev using an AES-192 key-schedule reference model.
module tb_rk_store_rev;
  localparam int NR = 12;
  localparam int CW = 4;

  logic          mclk = 1'b0;
  logic          arst_n = 1'b0;
  logic [0:127]  rk_in = '0;
  logic [CW-1:0] rk_in_count = '0;
  logic          rk_in_le = 1'b0;
  logic          rd_start = 1'b0;
  logic          rd_ready = 1'b0;
  logic [0:127]  rd_key;
  logic [CW-1:0] rd_round;
  logic          rd_valid;
  logic          keys_ready;
  logic          wr_err;

  rk_store_rev #(.NR(NR), .CNT_W(CW)) dut (
    .mclk(mclk), .arst_n(arst_n), .rk_in(rk_in), .rk_in_count(rk_in_count),
    .rk_in_le(rk_in_le), .rd_start(rd_start), .rd_ready(rd_ready),
    .rd_key(rd_key), .rd_round(rd_round), .rd_valid(rd_valid),
    .keys_ready(keys_ready), .wr_err(wr_err)
  );

  always #5 mclk = ~mclk;

  int           n_cmp = 0;
  int           n_bad = 0;
  logic [7:0]   sbox [256];
  logic [127:0] sched [0:NR];
  logic [127:0] exp_key_q [$];
  int           exp_rnd_q [$];
  logic [127:0] first_key = '0;
  logic [127:0] last_key = '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [127:0] m_invmix(input logic [127:0] k);
    logic [127:0] r;
    logic [7:0]   a [4];
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < 4; j++) a[j] = k[127-32*c-8*j -: 8];
      for (int j = 0; j < 4; j++)
        r[127-32*c-8*j -: 8] = gmul(a[j], 8'd14) ^ gmul(a[(j+1)%4], 8'd11) ^
                               gmul(a[(j+2)%4], 8'd13) ^ gmul(a[(j+3)%4], 8'd9);
    end
    return r;
  endfunction

  task automatic build_model();
    logic [7:0]  inv, t8, s;
    logic [31:0] w [0:51];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      if (x != 0)
        for (int y = 1; y < 256; y++)
          if (gmul(x[7:0], y[7:0]) == 8'h01) inv = y[7:0];
      s = inv;
      t8 = inv;
      repeat (4) begin
        t8 = {t8[6:0], t8[7]};
        s = s ^ t8;
      end
      sbox[x] = s ^ 8'h63;
    end
    for (int i = 0; i < 6; i++)
      w[i] = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
    rc = 8'h01;
    for (int i = 6; i < 52; i++) begin
      t = w[i-1];
      if (i % 6 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-6] ^ t;
    end
    for (int r = 0; r <= NR; r++)
      sched[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] expected_key(input int r);
    logic [127:0] k = sched[r];
`ifdef RK_INVMIX_EN
    if (r > 0 && r < NR) k = m_invmix(k);
`endif
    return k;
  endfunction

  task automatic push_replay();
    for (int r = NR; r >= 0; r--) begin
      exp_key_q.push_back(expected_key(r));
      exp_rnd_q.push_back(r);
    end
  endtask

  // Monitor: any presented key must match the queue head; a handshake retires it.
  always @(negedge mclk) begin
    if (arst_n) begin
      if (rd_valid) begin
        if (exp_key_q.size() == 0) begin
          check("unexpected_valid", 128'(rd_valid), 128'(0));
        end else begin
          check("rd_key", rd_key, exp_key_q[0]);
          check("rd_round", 128'(rd_round), 128'(exp_rnd_q[0]));
          if (rd_ready) begin
            if (rd_round == CW'(NR)) first_key = rd_key;
            if (rd_round == '0) last_key = rd_key;
            void'(exp_key_q.pop_front());
            void'(exp_rnd_q.pop_front());
          end
        end
      end else begin
        check("rd_key_idle", rd_key, 128'(0));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge mclk);
      #1;
    end
  endtask

  task automatic send(input int idx, input bit err);
    rk_in       = err ? {$urandom, $urandom, $urandom, $urandom} : sched[idx];
    rk_in_count = CW'(idx);
    rk_in_le    = 1'b1;
    @(posedge mclk);
    #1;
    rk_in_le = 1'b0;
    rk_in    = {$urandom, $urandom, $urandom, $urandom};
    check("wr_err", 128'(wr_err), 128'(err));
  endtask

  // Expander-style bursts of three with a bubble, plus optional random gaps and bad strobes.
  task automatic fill(input int from, input bit inject);
    for (int i = from; i <= NR; i++) begin
      if (inject && $urandom_range(0, 3) == 0) send(int'($urandom_range(i + 1, 15)), 1'b1);
      if (i == NR) check("keys_ready_before_last", 128'(keys_ready), 128'(0));
      send(i, 1'b0);
      if (i == NR) check("keys_ready_full", 128'(keys_ready), 128'(1));
      if ((i - from) % 3 == 2) idle(1);
      if (inject) idle(int'($urandom_range(0, 1)));
    end
  endtask

  task automatic replay(input int mode, input bit inject_wr);
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int cyc = 0;
    push_replay();
    rd_start = 1'b1;
    rd_ready = (mode == 0);
    @(posedge mclk);
    #1;
    rd_start = 1'b0;
    while (exp_key_q.size() > 0 && cyc < 200) begin
      case (mode)
        0:       rd_ready = 1'b1;
        1:       rd_ready = 1'($urandom_range(0, 1));
        default: rd_ready = pat[cyc % 4];
      endcase
      if (mode == 1) rd_start = ($urandom_range(0, 1) == 1) && (exp_key_q.size() > 2);
      if (inject_wr && cyc == 3) begin
        rk_in_le    = 1'b1;
        rk_in_count = '0;
        rk_in       = {$urandom, $urandom, $urandom, $urandom};
      end
      @(posedge mclk);
      #1;
      cyc++;
      if (inject_wr && cyc == 4) begin
        rk_in_le = 1'b0;
        check("wr_err_read", 128'(wr_err), 128'(1));
      end
    end
    rd_start = 1'b0;
    if (exp_key_q.size() > 0) begin
      check("replay_timeout", 128'(exp_key_q.size()), 128'(0));
      exp_key_q.delete();
      exp_rnd_q.delete();
    end
    if (mode == 0) check("replay_cycles", 128'(cyc), 128'(NR + 1));
    check("rd_valid_done", 128'(rd_valid), 128'(0));
    check("keys_ready_kept", 128'(keys_ready), 128'(1));
  endtask

  initial begin
    int cyc;
    build_model();
    idle(2);
    check("rst_keys_ready", 128'(keys_ready), 128'(0));
    check("rst_rd_valid", 128'(rd_valid), 128'(0));
    check("rst_wr_err", 128'(wr_err), 128'(0));
    check("rst_rd_round", 128'(rd_round), 128'(0));
    check("rst_rd_key", rd_key, 128'(0));
    arst_n = 1'b1;

    rd_start = 1'b1;
    idle(1);
    rd_start = 1'b0;
    idle(1);
    check("idle_rd_start_ignored", 128'(rd_valid), 128'(0));
    send(5, 1'b1);

    fill(0, 1'b0);
    replay(0, 1'b0);
    check("first_key_r12", first_key, 128'ha4970a331a78dc09c418c271e3a41d5d);
    check("last_key_r0", last_key, 128'h000102030405060708090a0b0c0d0e0f);
    replay(2, 1'b0);
    replay(1, 1'b1);

    send(0, 1'b0);
    check("refill_drops_ready", 128'(keys_ready), 128'(0));
    send(1, 1'b0);
    send(2, 1'b0);
    send(5, 1'b1);
    idle(1);
    check("wr_err_single_pulse", 128'(wr_err), 128'(0));
    fill(3, 1'b0);
    replay(0, 1'b0);

    rd_start = 1'b1;
    send(0, 1'b0);
    rd_start = 1'b0;
    check("prio_no_valid", 128'(rd_valid), 128'(0));
    check("prio_not_ready", 128'(keys_ready), 128'(0));
    fill(1, 1'b1);
    replay(1, 1'b0);

    push_replay();
    rd_start = 1'b1;
    rd_ready = 1'b1;
    idle(1);
    rd_start = 1'b0;
    cyc = 0;
    while (!(rd_valid && rd_round == CW'(7)) && cyc < 50) begin
      idle(1);
      cyc++;
    end
    if (cyc >= 50) check("wait_round7_timeout", 128'(cyc), 128'(0));
    #2;
    arst_n = 1'b0;
    #1;
    check("arst_rd_valid", 128'(rd_valid), 128'(0));
    check("arst_keys_ready", 128'(keys_ready), 128'(0));
    exp_key_q.delete();
    exp_rnd_q.delete();
    idle(2);
    arst_n = 1'b1;
    rd_start = 1'b1;
    idle(1);
    rd_start = 1'b0;
    idle(2);
    check("post_rst_no_replay", 128'(rd_valid), 128'(0));
    check("post_rst_not_ready", 128'(keys_ready), 128'(0));
    fill(0, 1'b1);
    replay(1, 1'b1);
    replay(0, 1'b0);

    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rk_store_rev.md
Name: rk_store_rev

Overview:
- Receiver end of the round-key interface (`rk`/`le`/`count`) driven by the key expanders, e.g. the 192-bit expander.
- Captures the round keys as they are emitted in forward order (round 0..NR) into a local register file.
- Replays them in reverse order (round NR..0) to the decryption datapath over a valid/ready handshake.
- Lets one forward-only expander serve the inverse cipher.

Parameters:
- NR, 12, number of rounds; legal values 10, 12, 14. Storage is NR+1 words of 128 bits.
- CNT_W, 4, width of round index fields.

Ports:
- mclk  input  1  master clock; all state on rising edge.
- arst_n  input  1  asynchronous active-low reset.
- rk_in  input  128 [0:127]  round key from the expander; valid when rk_in_le=1.
- rk_in_count  input  CNT_W  round index of rk_in.
- rk_in_le  input  1  load-enable strobe, one cycle per round key.
- rd_start  input  1  request reverse replay; honoured only when keys_ready=1.
- rd_ready  input  1  consumer accepts rd_key this cycle.
- rd_key  output  128 [0:127]  round key presented to the decryptor.
- rd_round  output  CNT_W  round index of rd_key.
- rd_valid  output  1  rd_key/rd_round valid.
- keys_ready  output  1  full schedule (0..NR) captured and held.
- wr_err  output  1  one-cycle pulse on an illegal write.

Behaviour:
- Reset (async, arst_n=0):
  - State IDLE; wr_ptr=0, rd_ptr=0.
  - keys_ready=0, rd_valid=0, wr_err=0, rd_round=0, rd_key=0.
  - Storage contents don't-care. Reset mid-fill or mid-read aborts immediately; no partial state survives.
- States: IDLE, FILL, FULL, READ.
- IDLE:
  - rk_in_le=1 with rk_in_count=0: write mem[0], wr_ptr<=1, go to FILL.
  - rk_in_le=1 with count≠0: ignore, pulse wr_err.
- FILL:
  - rk_in_le=1 with rk_in_count==wr_ptr: write mem[wr_ptr], wr_ptr++.
  - Writing index NR: go to FULL, keys_ready<=1 on the next edge.
  - rk_in_le with count==0: restart; write mem[0], wr_ptr<=1, stay in FILL.
  - Any other count: ignore and pulse wr_err; wr_ptr unchanged.
  - Gaps between strobes of any length are legal (the expander emits 1 key per cycle in bursts of 3 with a one-cycle bubble).
- FULL:
  - keys_ready=1.
  - rd_start=1: rd_ptr<=NR, go to READ.
  - rk_in_le with count 0: keys_ready<=0, restart fill (go to FILL as above). This has priority over a simultaneous rd_start.
  - rk_in_le with count≠0: ignore, pulse wr_err.
- READ:
  - rd_valid=1, rd_key=mem[rd_ptr], rd_round=rd_ptr.
  - rd_key and rd_round are held stable while rd_valid=1 and rd_ready=0.
  - Transfer occurs on rd_valid & rd_ready. On transfer with rd_ptr>0, rd_ptr--. On transfer with rd_ptr==0, go to FULL and rd_valid<=0.
  - keys remain stored; replay may be requested again any number of times.
  - Any rk_in_le during READ: ignored, wr_err pulse; keys unchanged.
  - rd_start during READ: ignored.
- Latency:
  - rd_start accepted at edge N → rd_valid=1 with round NR after edge N.
  - With rd_ready held 1, one key per cycle; NR+1 cycles for a full replay.
- rd_key is 0 whenever rd_valid=0.

Optional Feature:
- Macro RK_INVMIX_EN.
- When defined: round keys with index 1..NR-1 pass through InvMixColumns on each 32-bit column before driving rd_key. This gives the equivalent-inverse-cipher key schedule. Rounds 0 and NR pass unmodified. The transform is combinational on the read path, so latency is unchanged.
- When undefined: rd_key is always the raw stored key.

Test Plan:
- Reset, then feed AES-192 schedule for key 000102…1617 (counts 0..12 in expander burst pattern) → keys_ready=1 one cycle after the count-12 strobe; wr_err never asserted.
- rd_start with rd_ready=1 → rd_round 12,11,…,0 on consecutive cycles.
  - First rd_key = a4970a331a78dc09c418c271e3a41d5d.
  - Last rd_key = 000102030405060708090a0b0c0d0e0f.
  - Then rd_valid=0 and state FULL.
- rd_ready toggled 1-0-0-1 during READ → rd_key/rd_round stable across stalls; no key skipped or repeated.
- Strobe count 5 while wr_ptr=3 → wr_err one pulse, no write; subsequent counts 3.. complete normally.
- arst_n low while rd_round=7 → rd_valid=0, keys_ready=0 immediately. After release, rd_start ignored until a full reload.
- With RK_INVMIX_EN: round 12 and round 0 keys are unchanged; round 1..11 keys equal InvMixColumns of the raw keys (checked against reference model).
